// File: rtl/shared_pkg.sv
// Shared types for the SPI-to-RAM slave path: FSM states and 2-bit command codes.
package shared_pkg;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic is_shift(input spi_state_e s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_miso_shifter.sv
// Parallel-in/serial-out MISO shifter, MSB first; MISO idles at 0.
module spi_miso_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  miso,
  output logic                  active,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0]         cnt;

  // done marks the edge where the last bit retires and MISO drops back to 0
  assign done = active && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      sr     <= '0;
      cnt    <= '0;
      miso   <= 1'b0;
      active <= 1'b0;
    end else if (load) begin
      sr     <= din << 1;
      miso   <= din[DATA_WIDTH-1];
      cnt    <= CW'(DATA_WIDTH - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        miso   <= 1'b0;
        active <= 1'b0;
      end else begin
        miso <= sr[DATA_WIDTH-1];
        sr   <= sr << 1;
        cnt  <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front end: MOSI frame -> {cmd,payload} word, RAM read data -> MISO.
// Optional frame_err output enabled by defining SPI_FRAME_ERR_EN.
module spi_slave_param import shared_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  MISO,
  output logic                  rx_valid,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int W  = DATA_WIDTH + 2;
  localparam int BW = $clog2(W + 1);
  localparam logic [BW-1:0] LAST    = BW'(W - 1);
  localparam logic [BW-1:0] FULL    = BW'(W);
  localparam logic [15:0]   TO_LAST = 16'(TX_TIMEOUT - 1);

  spi_state_e    state, nstate;
  logic [W-2:0]  sr;
  logic [BW-1:0] bcnt;
  logic [15:0]   wcnt;
  logic          wait_q, rd_addr_seen;
  logic          in_word, abort, timeout, load, sh_done, sh_active;

  assign busy    = (state != IDLE);
  assign abort   = SS_n && (state != IDLE);
  assign in_word = is_shift(state) && (bcnt != FULL);
  // tx_valid only matters inside the post-word wait window of a read-data frame
  assign load    = wait_q && !SS_n && tx_valid && !sh_active;
  assign timeout = wait_q && !SS_n && !tx_valid && (wcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (!SS_n) nstate = CHK_CMD;
      CHK_CMD: nstate = MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
      default: nstate = state;
    endcase
    if (abort) nstate = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr           <= '0;
      bcnt         <= '0;
      wcnt         <= '0;
      wait_q       <= 1'b0;
      rd_addr_seen <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        bcnt   <= '0;
        wcnt   <= '0;
        wait_q <= 1'b0;
      end else begin
        if (in_word) begin
          sr   <= {sr[W-3:0], MOSI};
          bcnt <= bcnt + 1'b1;
          if (bcnt == LAST) begin
            rx_data  <= {sr, MOSI};
            rx_valid <= 1'b1;
            wait_q   <= (state == READ_DATA);
          end
        end
        if (wait_q) begin
          if (load || timeout) wait_q <= 1'b0;
          else                 wcnt   <= wcnt + 1'b1;
        end
      end
      // a finished or timed-out read consumes the stored address; an abort does not
      if (!abort && in_word && (bcnt == LAST) && (state == READ_ADD))
        rd_addr_seen <= 1'b1;
      else if (timeout || sh_done)
        rd_addr_seen <= 1'b0;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= timeout ||
                          (abort && (in_word || (state == CHK_CMD) || (sh_active && !sh_done)));
  end
`endif

  spi_miso_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_miso (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .abort  (abort),
    .din    (tx_data),
    .miso   (MISO),
    .active (sh_active),
    .done   (sh_done)
  );

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: vector table of frames plus hand sequences for reset, abort and timeout.
module tb_spi_slave_param;

  localparam int DW = 8;
  localparam int TO = 16;
  localparam int W  = DW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          MISO, rx_valid, busy;
  logic [W-1:0]  rx_data;
`ifdef SPI_FRAME_ERR_EN
  logic          frame_err;
`endif

  int errors = 0, checks = 0;
  logic [W-1:0] exp_q[$];

  spi_slave_param #(.DATA_WIDTH(DW), .TX_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .MISO     (MISO),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every rx_valid pulse must match the oldest pushed word
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic frame(input logic sel, input logic [W-1:0] w, input int nbits);
    SS_n = 1'b0; MOSI = 1'b0; tick;
    MOSI = sel; tick;
    check("busy_frame", busy, 1);
    if (nbits == W) exp_q.push_back(w);
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[W-1-i];
      tick;
    end
    if (nbits == W) check("rx_latency", rx_valid, 1);
    MOSI = 1'($urandom);
  endtask

  task automatic txread(input int dly, input logic [DW-1:0] d, output logic [DW-1:0] got,
                        output logic tail);
    tx_valid = 1'b0;
    repeat (dly) tick;
    tx_valid = 1'b1; tx_data = d; tick;
    tx_valid = 1'b0; tx_data = 8'($urandom);
    for (int i = 0; i < DW; i++) begin
      got[DW-1-i] = MISO;
      MOSI = 1'($urandom);
      tick;
    end
    tail = MISO;
  endtask

  task automatic end_frame;
    SS_n = 1'b1; tick;
    check("busy_idle", busy, 0);
`ifdef SPI_FRAME_ERR_EN
    check("ferr_clean_end", frame_err, 0);
`endif
  endtask

  typedef struct {
    logic          rst_first;
    logic          sel;
    logic [W-1:0]  w;
    logic [DW-1:0] txd;
    logic          rd;
  } vec_t;

  vec_t          tbl[6];
  logic [DW-1:0] got;
  logic          tail;
  logic          acc;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 10'h0A5, 8'hFF, 1'b0};  // write address, tx ignored
    tbl[1] = '{1'b0, 1'b1, 10'h23C, 8'h5A, 1'b0};  // read address
    tbl[2] = '{1'b0, 1'b1, 10'h300, 8'hC3, 1'b1};  // read data
    tbl[3] = '{1'b0, 1'b0, 10'h1F0, 8'h81, 1'b0};  // write data
    tbl[4] = '{1'b1, 1'b1, 10'h3AB, 8'hFF, 1'b0};  // fresh reset: read-data cmd becomes READ_ADD
    tbl[5] = '{1'b0, 1'b1, 10'h3EE, 8'h96, 1'b1};  // now a real read

    // reset dominates SS_n/MOSI/tx_valid activity
    rst = 1'b1; SS_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      MOSI = i[0]; tx_valid = ~i[0]; tx_data = 8'hA5;
      tick;
      check("reset_outs", {MISO, rx_valid, busy, rx_data}, 0);
    end
    rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0; tick;

    for (int r = 0; r < 6; r++) begin
      if (tbl[r].rst_first) begin
        rst = 1'b1; tick; tick; rst = 1'b0;
      end
      frame(tbl[r].sel, tbl[r].w, W);
      txread(0, tbl[r].txd, got, tail);
      check("miso_bits", got, tbl[r].rd ? tbl[r].txd : 8'h00);
      check("miso_tail", tail, 0);
      check("rx_hold", rx_data, tbl[r].w);
      end_frame;
    end

    // abort after 4 payload bits of a write frame
    SS_n = 1'b0; MOSI = 1'b0; tick;
    tick;
    for (int i = 0; i < 4; i++) begin MOSI = i[0]; tick; end
    SS_n = 1'b1; tick;
    check("abort_busy", busy, 0);
    check("abort_rxv", rx_valid, 0);
`ifdef SPI_FRAME_ERR_EN
    check("abort_ferr", frame_err, 1);
    tick;
    check("abort_ferr_pulse", frame_err, 0);
`endif
    frame(1'b0, 10'h155, W);
    check("after_abort_rx", rx_data, 10'h155);
    end_frame;

    // an aborted read-data frame keeps the stored address
    frame(1'b1, 10'h211, W); end_frame;
    frame(1'b1, 10'h3FF, 3); end_frame;
    frame(1'b1, 10'h300, W);
    txread(0, 8'hA5, got, tail);
    check("addr_kept_miso", got, 8'hA5);
    end_frame;

    // tx_valid on the last cycle of the wait window is still accepted
    frame(1'b1, 10'h201, W); end_frame;
    frame(1'b1, 10'h3C0, W);
    txread(TO - 1, 8'h3C, got, tail);
    check("late_tx_miso", got, 8'h3C);
    check("late_tx_tail", tail, 0);
    end_frame;

    // timeout: tx_valid one cycle too late is ignored
    frame(1'b1, 10'h2AA, W); end_frame;
    frame(1'b1, 10'h355, W);
    tx_valid = 1'b0;
    repeat (TO) tick;
`ifdef SPI_FRAME_ERR_EN
    check("to_ferr", frame_err, 1);
`endif
    tx_valid = 1'b1; tx_data = 8'hFF; tick;
    tx_valid = 1'b0;
    acc = 1'b0;
    repeat (10) begin acc |= MISO; tick; end
    check("to_miso", acc, 0);
    check("to_busy", busy, 1);
    end_frame;
    frame(1'b1, 10'h3FF, W);
    txread(0, 8'h77, got, tail);
    check("to_addr_cleared", got, 8'h00);
    end_frame;
    frame(1'b1, 10'h300, W);
    txread(0, 8'h77, got, tail);
    check("to_recover", got, 8'h77);
    end_frame;

    repeat (3) tick;
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised next-generation SPI slave front end for the SPI-to-single-port-RAM path. It deserialises MOSI frames of (DATA_WIDTH+2) bits into a command+payload word for the RAM, then serialises RAM read data back on MISO. Compared with the fixed 10-bit slave, it generalises the word width and adds a read-data timeout, abort handling and a busy indication. It sits between the SPI pins and the RAM wrapper.

Parameters:
DATA_WIDTH, 8, RAM data/address width; rx word is DATA_WIDTH+2 bits (2-bit command + payload).
TX_TIMEOUT, 16, max cycles to wait for tx_valid after a read-data command; legal range is 1 to 2^16-1.

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
SS_n  in  1  slave select, active low.
MOSI  in  1  serial input; sampled on clk rising edge while SS_n=0.
tx_valid  in  1  RAM read data valid.
tx_data  in  DATA_WIDTH  RAM read data.
MISO  out  1  serial output.
rx_valid  out  1  one-cycle pulse; rx_data holds a valid word.
rx_data  out  DATA_WIDTH+2  {cmd[1:0], payload}, MSB first as received.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, MISO=0, rx_valid=0, rx_data=0, busy=0, rd_addr_seen=0, all counters=0. Reset dominates every other input.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE to CHK_CMD occurs on the first edge with SS_n=0.
- CHK_CMD samples the select bit on MOSI:
  - 0 goes to WRITE.
  - 1 goes to READ_DATA if rd_addr_seen=1, else READ_ADD.
- WRITE, READ_ADD and READ_DATA each shift in W=DATA_WIDTH+2 bits, MSB first.
- On the edge that samples bit W:
  - rx_data is loaded and rx_valid=1 for exactly the following cycle.
  - rx_data keeps its value until the next completed word.
- READ_ADD completion sets rd_addr_seen=1.
- READ_DATA, after its rx_valid pulse, waits for tx_valid:
  - The first edge with tx_valid=1 latches tx_data.
  - From the next cycle, MISO drives tx_data[DATA_WIDTH-1] down to [0], one bit per cycle.
  - MISO then returns to 0 and rd_addr_seen clears.
- tx_valid is ignored in any state other than the READ_DATA wait window.
- Timeout: if TX_TIMEOUT cycles elapse after the rx_valid pulse without tx_valid:
  - MISO stays 0 and rd_addr_seen clears.
  - State holds until SS_n=1.
- SS_n=1 at any edge in a non-IDLE state:
  - State goes to IDLE next cycle and bit/wait counters clear.
  - A partial word is discarded with no rx_valid.
  - A MISO shift in progress is aborted and MISO=0.
  - rd_addr_seen is preserved unless the read completed or timed out.
- After a full word, extra MOSI bits while SS_n=0 are ignored.
- Latency: SS_n fall to rx_valid is W+2 edges.

Optional Feature:
Macro SPI_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit, reset 0). It pulses for one cycle when SS_n rises mid-word or mid-MISO-shift, or when the read timeout fires.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- shared_pkg holds:
  - enum spi_state_e {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA};
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- One sub-module, spi_miso_shifter: a DATA_WIDTH-bit parallel-in/serial-out shifter with load, abort and done.

Test Plan (DATA_WIDTH=8, TX_TIMEOUT=16):
1. Reset: hold rst=1 with SS_n=0 and MOSI toggling → MISO=0, rx_valid=0, rx_data=0, busy=0 throughout.
2. Write address: SS_n low, MOSI 0 then 00_1010_0101 → rx_valid pulse 12 edges after the SS_n fall, rx_data=10'h0A5, no MISO activity.
3. Read address then read data:
   - Frame 1: 1 then 10_0011_1100 → rx_data=10'h23C.
   - Frame 2: 1 then 11_0000_0000 → rx_data=10'h300.
   - tx_valid with tx_data=8'hC3 → MISO sequence 1,1,0,0,0,0,1,1, then 0.
4. Read data without a prior read address: fresh reset, frame 1 then 11_xxxxxxxx → decoded as READ_ADD. A following read frame enters READ_DATA.
5. Abort: SS_n rises after 4 payload bits → no rx_valid, IDLE and busy=0 next cycle, frame_err pulse if SPI_FRAME_ERR_EN. The next full frame decodes correctly.
6. Timeout: read-data frame with no tx_valid for 16 cycles → MISO=0, busy held until SS_n=1, rd_addr_seen cleared, frame_err pulse if enabled. tx_valid at cycle 17 is ignored.
